// File: rtl/bcd_convert_sched_if.sv
// Request/result bundle for the two-requester binary-to-BCD converter.
// The master side drives requests and operands; the slave side answers with grants and results.
interface bcd_convert_sched_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic [1:0]          req;
  logic [WIDTH-1:0]    bin0;
  logic [WIDTH-1:0]    bin1;
  logic [1:0]          ack;
  logic                busy;
  logic                out_valid;
  logic                out_tag;
  logic [DIGITS*4-1:0] bcdout;
  logic                overflow;

  modport master (output req, bin0, bin1,
                  input  ack, busy, out_valid, out_tag, bcdout, overflow);
  modport slave  (input  req, bin0, bin1,
                  output ack, busy, out_valid, out_tag, bcdout, overflow);
endinterface

// File: rtl/bcd_convert_sched.sv
// Round-robin shared double-dabble converter: one operand bit per clock, MSB first.
// The result registers hold their value until the next conversion completes.
module bcd_convert_sched #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input logic               clk,
  input logic               rst,
  bcd_convert_sched_if.slave bus
);
  localparam int SW = DIGITS * 4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            cur_tag_q, cur_tag_d;
  logic [1:0]      ack_q, ack_d;
  logic            out_valid_q, out_valid_d;
  logic            out_tag_q, out_tag_d;
  logic [SW-1:0]   bcdout_q, bcdout_d;
  logic            overflow_q, overflow_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_acc_q, ovf_acc_d;

  logic [SW-1:0]   adj;
  logic [SW-1:0]   stepped;
  logic            carry;
  logic            win;

  // Per-digit +3 correction ahead of the shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                         : scratch_q[4*k +: 4];
  end

  assign carry   = adj[SW-1];
  assign stepped = {adj[SW-2:0], opnd_q[WIDTH-1]};

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cur_tag_d   = cur_tag_q;
    ack_d       = 2'b00;
    out_valid_d = 1'b0;
    out_tag_d   = out_tag_q;
    bcdout_d    = bcdout_q;
    overflow_d  = overflow_q;
    scratch_d   = scratch_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    win         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win       = (bus.req == 2'b11) ? rr_q : bus.req[1];
          opnd_d    = win ? bus.bin1 : bus.bin0;
          ack_d     = win ? 2'b10 : 2'b01;
          rr_d      = ~win;
          cur_tag_d = win;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = stepped;
        opnd_d    = opnd_q << 1;
        ovf_acc_d = ovf_acc_q | carry;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          bcdout_d    = stepped;
          overflow_d  = ovf_acc_q | carry;
          out_tag_d   = cur_tag_q;
          out_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cur_tag_q   <= 1'b0;
      ack_q       <= 2'b00;
      out_valid_q <= 1'b0;
      out_tag_q   <= 1'b0;
      bcdout_q    <= '0;
      overflow_q  <= 1'b0;
      scratch_q   <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cur_tag_q   <= cur_tag_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      bcdout_q    <= bcdout_d;
      overflow_q  <= overflow_d;
      scratch_q   <= scratch_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.bcdout    = bcdout_q;
  assign bus.overflow  = overflow_q;
endmodule
